// File: rtl/id_stage.sv
// id_stage: RV32I decode stage with same-cycle WB bypass, load-use interlock
// and the ID/EX pipeline register.
module id_stage #(
    parameter bit BYPASS_WB = 1'b1
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        if_valid,
    input  logic [31:0] if_pc,
    input  logic [31:0] if_instr,
    output logic        id_ready,
    output logic        rf_r1_en,
    output logic        rf_r2_en,
    output logic [4:0]  rf_r1_addr,
    output logic [4:0]  rf_r2_addr,
    input  logic [31:0] rf_r1_data,
    input  logic [31:0] rf_r2_data,
    input  logic        wb_we,
    input  logic [4:0]  wb_addr,
    input  logic [31:0] wb_data,
    input  logic        flush,
    input  logic        ex_ready,
    output logic        ex_valid,
    output logic [31:0] ex_pc,
    output logic [31:0] ex_rs1_val,
    output logic [31:0] ex_rs2_val,
    output logic [31:0] ex_imm,
    output logic [4:0]  ex_rs1,
    output logic [4:0]  ex_rs2,
    output logic [4:0]  ex_rd,
    output logic [3:0]  ex_alu_op,
    output logic        ex_alu_src_imm,
    output logic        ex_alu_src_pc,
    output logic        ex_mem_read,
    output logic        ex_mem_write,
    output logic [2:0]  ex_funct3,
    output logic        ex_reg_write,
    output logic        ex_branch,
    output logic        ex_jal,
    output logic        ex_jalr,
    output logic        ex_illegal
);
    localparam logic [6:0] OPC_LUI    = 7'b0110111;
    localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
    localparam logic [6:0] OPC_JAL    = 7'b1101111;
    localparam logic [6:0] OPC_JALR   = 7'b1100111;
    localparam logic [6:0] OPC_BRANCH = 7'b1100011;
    localparam logic [6:0] OPC_LOAD   = 7'b0000011;
    localparam logic [6:0] OPC_STORE  = 7'b0100011;
    localparam logic [6:0] OPC_OPIMM  = 7'b0010011;
    localparam logic [6:0] OPC_OP     = 7'b0110011;
    localparam logic [6:0] OPC_MISC   = 7'b0001111;

    localparam logic [3:0] ALU_ADD  = 4'd0;
    localparam logic [3:0] ALU_SUB  = 4'd1;
    localparam logic [3:0] ALU_SLL  = 4'd2;
    localparam logic [3:0] ALU_SLT  = 4'd3;
    localparam logic [3:0] ALU_SLTU = 4'd4;
    localparam logic [3:0] ALU_XOR  = 4'd5;
    localparam logic [3:0] ALU_SRL  = 4'd6;
    localparam logic [3:0] ALU_SRA  = 4'd7;
    localparam logic [3:0] ALU_OR   = 4'd8;
    localparam logic [3:0] ALU_AND  = 4'd9;
    localparam logic [3:0] ALU_PASS = 4'd10;

    typedef struct packed {
        logic        valid;
        logic [31:0] pc;
        logic [31:0] rs1_val;
        logic [31:0] rs2_val;
        logic [31:0] imm;
        logic [4:0]  rs1;
        logic [4:0]  rs2;
        logic [4:0]  rd;
        logic [3:0]  alu_op;
        logic        src_imm;
        logic        src_pc;
        logic        mem_read;
        logic        mem_write;
        logic [2:0]  funct3;
        logic        reg_write;
        logic        branch;
        logic        jal;
        logic        jalr;
        logic        illegal;
    } idex_t;

    idex_t dec, idex_d, idex_q;

    logic [6:0]  opc;
    logic [4:0]  rs1, rs2, rd, ers1, ers2;
    logic [2:0]  f3;
    logic        use1, use2, hazard, advance, load;
    logic [31:0] imm_i, imm_s, imm_b, imm_u, imm_j, rs1_val, rs2_val;
    logic [3:0]  alu_f3;

    assign opc   = if_instr[6:0];
    assign rd    = if_instr[11:7];
    assign f3    = if_instr[14:12];
    assign rs1   = if_instr[19:15];
    assign rs2   = if_instr[24:20];
    assign imm_i = {{20{if_instr[31]}}, if_instr[31:20]};
    assign imm_s = {{20{if_instr[31]}}, if_instr[31:25], if_instr[11:7]};
    assign imm_b = {{20{if_instr[31]}}, if_instr[7], if_instr[30:25], if_instr[11:8], 1'b0};
    assign imm_u = {if_instr[31:12], 12'b0};
    assign imm_j = {{12{if_instr[31]}}, if_instr[19:12], if_instr[20], if_instr[30:21], 1'b0};

    assign use1 = !(opc == OPC_LUI || opc == OPC_AUIPC || opc == OPC_JAL);
    assign use2 = opc == OPC_OP || opc == OPC_STORE || opc == OPC_BRANCH;
    assign ers1 = use1 ? rs1 : 5'd0;
    assign ers2 = use2 ? rs2 : 5'd0;

    assign rf_r1_en   = if_valid & use1;
    assign rf_r2_en   = if_valid & use2;
    assign rf_r1_addr = rs1;
    assign rf_r2_addr = rs2;

    // Unused or x0 indices never match, so they keep the register file's zero.
    assign rs1_val = (BYPASS_WB && wb_we && wb_addr == ers1 && ers1 != 5'd0) ? wb_data : rf_r1_data;
    assign rs2_val = (BYPASS_WB && wb_we && wb_addr == ers2 && ers2 != 5'd0) ? wb_data : rf_r2_data;

    always_comb begin
        case (f3)
            3'd0:    alu_f3 = (opc == OPC_OP && if_instr[30]) ? ALU_SUB : ALU_ADD;
            3'd1:    alu_f3 = ALU_SLL;
            3'd2:    alu_f3 = ALU_SLT;
            3'd3:    alu_f3 = ALU_SLTU;
            3'd4:    alu_f3 = ALU_XOR;
            3'd5:    alu_f3 = if_instr[30] ? ALU_SRA : ALU_SRL;
            3'd6:    alu_f3 = ALU_OR;
            default: alu_f3 = ALU_AND;
        endcase
    end

    always_comb begin
        dec         = '0;
        dec.valid   = 1'b1;
        dec.pc      = if_pc;
        dec.rs1_val = rs1_val;
        dec.rs2_val = rs2_val;
        dec.imm     = imm_i;
        dec.rs1     = ers1;
        dec.rs2     = ers2;
        dec.alu_op  = ALU_ADD;
        dec.funct3  = f3;
        case (opc)
            OPC_LUI:    begin dec.reg_write = 1'b1; dec.src_imm = 1'b1; dec.alu_op = ALU_PASS; dec.imm = imm_u; end
            OPC_AUIPC:  begin dec.reg_write = 1'b1; dec.src_imm = 1'b1; dec.src_pc = 1'b1; dec.imm = imm_u; end
            OPC_JAL:    begin dec.reg_write = 1'b1; dec.src_imm = 1'b1; dec.src_pc = 1'b1; dec.jal = 1'b1; dec.imm = imm_j; end
            OPC_JALR:   begin dec.reg_write = 1'b1; dec.src_imm = 1'b1; dec.jalr = 1'b1; end
            // Branches compare rs1 against rs2 in the ALU.
            OPC_BRANCH: begin dec.branch = 1'b1; dec.alu_op = ALU_SUB; dec.imm = imm_b; end
            OPC_LOAD:   begin dec.reg_write = 1'b1; dec.src_imm = 1'b1; dec.mem_read = 1'b1; end
            OPC_STORE:  begin dec.mem_write = 1'b1; dec.src_imm = 1'b1; dec.imm = imm_s; end
            OPC_OPIMM:  begin dec.reg_write = 1'b1; dec.src_imm = 1'b1; dec.alu_op = alu_f3; end
            OPC_OP:     begin dec.reg_write = 1'b1; dec.alu_op = alu_f3; end
            OPC_MISC:   dec.illegal = 1'b0;
            default:    dec.illegal = 1'b1;
        endcase
        dec.rd        = (dec.reg_write && rd != 5'd0) ? rd : 5'd0;
        dec.reg_write = dec.reg_write && rd != 5'd0;
    end

    assign hazard  = idex_q.valid && idex_q.mem_read && idex_q.rd != 5'd0 &&
                     ((use1 && idex_q.rd == rs1) || (use2 && idex_q.rd == rs2));
    assign advance = ex_ready | ~idex_q.valid;
    assign load    = advance & if_valid & ~hazard & ~flush;
    assign id_ready = ~reset & (flush | (advance & ~hazard));

    // Every non-loading advance and every flush leaves a bubble; data fields hold.
    always_comb begin
        idex_d = load ? dec : idex_q;
        if (flush || (advance && !load)) begin
            idex_d.valid     = 1'b0;
            idex_d.reg_write = 1'b0;
            idex_d.mem_read  = 1'b0;
            idex_d.mem_write = 1'b0;
            idex_d.branch    = 1'b0;
            idex_d.jal       = 1'b0;
            idex_d.jalr      = 1'b0;
            idex_d.illegal   = 1'b0;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) idex_q <= '0;
        else       idex_q <= idex_d;
    end

    assign ex_valid       = idex_q.valid;
    assign ex_pc          = idex_q.pc;
    assign ex_rs1_val     = idex_q.rs1_val;
    assign ex_rs2_val     = idex_q.rs2_val;
    assign ex_imm         = idex_q.imm;
    assign ex_rs1         = idex_q.rs1;
    assign ex_rs2         = idex_q.rs2;
    assign ex_rd          = idex_q.rd;
    assign ex_alu_op      = idex_q.alu_op;
    assign ex_alu_src_imm = idex_q.src_imm;
    assign ex_alu_src_pc  = idex_q.src_pc;
    assign ex_mem_read    = idex_q.mem_read;
    assign ex_mem_write   = idex_q.mem_write;
    assign ex_funct3      = idex_q.funct3;
    assign ex_reg_write   = idex_q.reg_write;
    assign ex_branch      = idex_q.branch;
    assign ex_jal         = idex_q.jal;
    assign ex_jalr        = idex_q.jalr;
    assign ex_illegal     = idex_q.illegal;
endmodule
